// File: rtl/booth_arbiter_if.sv
// Bundle of the two requester ports, the shared response port and the
// Booth multiplier port of booth_arbiter. The arbiter uses the slave view;
// the requesters and the multiplier together form the master view.
interface booth_arbiter_if #(
  parameter int W = 8
);
  // Requester side
  logic           req0_valid;
  logic           req1_valid;
  logic [W-1:0]   req0_a;
  logic [W-1:0]   req0_b;
  logic [W-1:0]   req1_a;
  logic [W-1:0]   req1_b;
  logic           req0_ready;
  logic           req1_ready;

  // Response side (product and error are shared by both response ports)
  logic           resp0_valid;
  logic           resp1_valid;
  logic           resp0_ready;
  logic           resp1_ready;
  logic [2*W-1:0] resp_p;
  logic           resp_err;

  // Multiplier side
  logic           mul_valid;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic           mul_done;
  logic [2*W-1:0] mul_p;

  // Status
  logic           busy;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp_p, resp_err,
    input  resp0_ready, resp1_ready,
    output mul_valid, mul_a, mul_b,
    input  mul_done, mul_p,
    output busy
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid, resp_p, resp_err,
    output resp0_ready, resp1_ready,
    input  mul_valid, mul_a, mul_b,
    output mul_done, mul_p,
    input  busy
  );
endinterface

// File: rtl/booth_arbiter.sv
// Two-requester arbiter in front of a single multi-cycle Booth multiplier.
// One operation is in flight at a time: accept in IDLE, pulse the
// multiplier in ISSUE, wait for completion or timeout in WAIT, and hold the
// result in RESP until the owning requester takes it. Grants alternate
// between the requesters when both are pending.
module booth_arbiter #(
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  booth_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // WAIT lasts at most TIMEOUT cycles: the timer counts 0..TIMEOUT-1 and the
  // abort fires in the cycle the timer reaches its last value.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t         r_state;
  state_t         w_next_state;

  logic           r_last_grant;
  logic           r_owner;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [7:0]     r_timer;
  logic [2*W-1:0] r_resp_p;
  logic           r_resp_err;

  logic           w_grant;
  logic           w_accept;
  logic           w_timeout;
  logic           w_owner_ready;
  logic [W-1:0]   w_sel_a;
  logic [W-1:0]   w_sel_b;

  logic           w_req0_ready;
  logic           w_req1_ready;
  logic           w_resp0_valid;
  logic           w_resp1_valid;
  logic           w_mul_valid;
  logic           w_busy;

  // Pick the requester to serve: a lone requester wins, otherwise the one
  // that was not served last.
  always_comb begin
    w_grant = ~r_last_grant;
    if (bus.req0_valid && !bus.req1_valid) begin
      w_grant = 1'b0;
    end else if (bus.req1_valid && !bus.req0_valid) begin
      w_grant = 1'b1;
    end
  end

  // The grant always points at a pending requester when any is pending, so
  // an accept happens whenever IDLE sees at least one valid.
  assign w_accept      = (r_state == S_IDLE) && (bus.req0_valid || bus.req1_valid);
  assign w_sel_a       = w_grant ? bus.req1_a : bus.req0_a;
  assign w_sel_b       = w_grant ? bus.req1_b : bus.req0_b;
  assign w_timeout     = (r_timer == TMO_LAST);
  assign w_owner_ready = r_owner ? bus.resp1_ready : bus.resp0_ready;

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the values from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and per-state outputs of the control FSM.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    w_next_state  = r_state;
    w_req0_ready  = 1'b0;
    w_req1_ready  = 1'b0;
    w_resp0_valid = 1'b0;
    w_resp1_valid = 1'b0;
    w_mul_valid   = 1'b0;
    w_busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy       = 1'b0;
        w_req0_ready = ~w_grant;
        w_req1_ready = w_grant;
        if (w_accept) begin
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_mul_valid  = 1'b1;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mul_done || w_timeout) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        w_resp0_valid = ~r_owner;
        w_resp1_valid = r_owner;
        if (w_owner_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Operand latch, WAIT timer, result capture and fairness bookkeeping.
  // A completion pulse outside WAIT falls through untouched, and mul_done
  // takes precedence over the timeout in the final WAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_timer      <= '0;
      r_resp_p     <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_owner <= w_grant;
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
        end
        S_WAIT: begin
          if (bus.mul_done) begin
            r_resp_p   <= bus.mul_p;
            r_resp_err <= 1'b0;
          end else if (w_timeout) begin
            r_resp_p   <= '0;
            r_resp_err <= 1'b1;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        S_RESP: begin
          if (w_owner_ready) begin
            r_last_grant <= r_owner;
          end
        end
        default: begin
          r_timer <= '0;
        end
      endcase
    end
  end

  assign bus.req0_ready  = w_req0_ready;
  assign bus.req1_ready  = w_req1_ready;
  assign bus.resp0_valid = w_resp0_valid;
  assign bus.resp1_valid = w_resp1_valid;
  assign bus.resp_p      = r_resp_p;
  assign bus.resp_err    = r_resp_err;
  assign bus.mul_valid   = w_mul_valid;
  assign bus.mul_a       = r_a;
  assign bus.mul_b       = r_b;
  assign bus.busy        = w_busy;

endmodule

// File: tb/tb_booth_arbiter.sv
// Testbench for booth_arbiter: directed scenarios followed by a randomized
// two-requester run. Accepted requests push their expected response into a
// scoreboard queue; an independent monitor pops and compares at each
// response handshake. A behavioural multiplier answers after a per-operation
// delay chosen by the stimulus.
module tb_booth_arbiter;

  localparam int W       = 8;
  localparam int TIMEOUT = 8;

  typedef struct {
    bit             owner;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    bit             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  booth_arbiter_if #(.W(W)) bus ();

  booth_arbiter #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  int   delay_q[$];
  bit   model_last = 1'b1;   // requester served most recently
  bit   rr_auto    = 1'b1;   // response-ready driver active
  bit   rr_random  = 1'b0;   // random backpressure when active
  int   grant_log[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_bound(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Expected response from the operands and the multiplier delay: the
  // multiplier result is taken if it arrives within TIMEOUT cycles of the
  // start pulse, otherwise the operation is aborted with a zero product.
  task automatic note_accept(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int d);
    exp_t e;
    int   prod;
    prod    = int'($signed(a)) * int'($signed(b));
    e.owner = id;
    e.a     = a;
    e.b     = b;
    if (d == 0 || d > TIMEOUT) begin
      e.p   = '0;
      e.err = 1'b1;
    end else begin
      e.p   = prod[2*W-1:0];
      e.err = 1'b0;
    end
    exp_q.push_back(e);
    delay_q.push_back(d);
  endtask

  task automatic set_req(input bit id, input bit v, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id) begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  function automatic bit ready_of(input bit id);
    return id ? bus.req1_ready : bus.req0_ready;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] r;
    r = W'($urandom);
    return r;
  endfunction

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return 0;
    if (r == 1) return TIMEOUT;
    if (r == 2) return TIMEOUT + 1;
    return int'($urandom_range(1, 6));
  endfunction

  // Present one request, wait for acceptance, withdraw it.
  task automatic issue(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int d, output int acc);
    acc = -1;
    @(posedge clk); #1;
    set_req(id, 1'b1, a, b);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ready_of(id)) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) fail_bound("accept_wait");
    else note_accept(id, a, b, d);
    @(posedge clk); #1;
    set_req(id, 1'b0, a, b);
  endtask

  task automatic wait_resp(input bit id, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (id ? bus.resp1_valid : bus.resp0_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) fail_bound("resp_wait");
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_bound("drain_wait");
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    delay_q.delete();
    model_last = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // Hold both requesters valid, reloading operands after each accept,
  // and log the grant order.
  task automatic drive_both(input int n);
    logic [W-1:0] a0, b0, a1, b1;
    int           d0, d1, got, guard;
    bit           id;
    got = 0; guard = 0;
    grant_log.delete();
    a0 = rnd_op(); b0 = rnd_op(); d0 = int'($urandom_range(1, 6));
    a1 = rnd_op(); b1 = rnd_op(); d1 = int'($urandom_range(1, 6));
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, a0, b0);
    set_req(1'b1, 1'b1, a1, b1);
    while (got < n && guard < 400) begin
      @(negedge clk);
      guard++;
      if (bus.req0_ready || bus.req1_ready) begin
        id = bus.req1_ready;
        if (id) note_accept(1'b1, a1, b1, d1);
        else    note_accept(1'b0, a0, b0, d0);
        grant_log.push_back(int'(id));
        got++;
        @(posedge clk); #1;
        if (id) begin
          a1 = rnd_op(); b1 = rnd_op(); d1 = int'($urandom_range(1, 6));
          set_req(1'b1, 1'b1, a1, b1);
        end else begin
          a0 = rnd_op(); b0 = rnd_op(); d0 = int'($urandom_range(1, 6));
          set_req(1'b0, 1'b1, a0, b0);
        end
      end
    end
    if (got < n) begin
      fail_bound("contention_accepts");
      @(posedge clk); #1;
    end
    set_req(1'b0, 1'b0, a0, b0);
    set_req(1'b1, 1'b0, a1, b1);
  endtask

  task automatic req_proc(input bit id, input int n);
    int acc;
    for (int k = 0; k < n; k++) begin
      repeat (int'($urandom_range(0, 3))) @(posedge clk);
      issue(id, rnd_op(), rnd_op(), pick_delay(), acc);
    end
  endtask

  // Behavioural multiplier: answers after the delay chosen for the
  // operation, or never when that delay is 0.
  int             mm_d;
  int             mm_prod;
  initial begin : mul_model
    bus.mul_done = 1'b0;
    bus.mul_p    = '0;
    forever begin
      @(negedge clk);
      if (rst && bus.mul_valid) begin
        mm_d = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
        if (exp_q.size() > 0) begin
          check("mul_a_issue", bus.mul_a, exp_q[0].a);
          check("mul_b_issue", bus.mul_b, exp_q[0].b);
        end else begin
          fail_bound("mul_valid_no_op");
        end
        mm_prod = int'($signed(bus.mul_a)) * int'($signed(bus.mul_b));
        if (mm_d > 0) begin
          repeat (mm_d) @(posedge clk);
          #1;
          bus.mul_done = 1'b1;
          bus.mul_p    = mm_prod[2*W-1:0];
          @(posedge clk); #1;
          bus.mul_done = 1'b0;
        end
      end
    end
  end

  // Response-ready driver.
  initial begin : rr_driver
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rr_auto) begin
        if (rr_random) begin
          bus.resp0_ready = ($urandom_range(0, 3) != 0);
          bus.resp1_ready = ($urandom_range(0, 3) != 0);
        end else begin
          bus.resp0_ready = 1'b1;
          bus.resp1_ready = 1'b1;
        end
      end
    end
  end

  // Scoreboard monitor: every response cycle is compared with the head of
  // the expected queue; the head is retired at the owner's handshake.
  exp_t mon_e;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst && (bus.resp0_valid || bus.resp1_valid)) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", {bus.resp1_valid, bus.resp0_valid}, 2'b00);
        end else begin
          mon_e = exp_q[0];
          check("resp_valid_vec", {bus.resp1_valid, bus.resp0_valid},
                mon_e.owner ? 2'b10 : 2'b01);
          check("resp_p", bus.resp_p, mon_e.p);
          check("resp_err", bus.resp_err, mon_e.err);
          check("mul_a_hold", bus.mul_a, mon_e.a);
          check("mul_b_hold", bus.mul_b, mon_e.b);
          check("busy_in_resp", bus.busy, 1'b1);
          if (mon_e.owner ? (bus.resp1_valid && bus.resp1_ready)
                          : (bus.resp0_valid && bus.resp0_ready)) begin
            void'(exp_q.pop_front());
            model_last = mon_e.owner;
          end
        end
      end
    end
  end

  // Arbitration checker: ready only while idle, and pointed at the lone
  // requester or, under contention, away from the last one served.
  bit arb_g;
  initial begin : arb_checker
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.busy) begin
          check("ready_when_busy", {bus.req1_ready, bus.req0_ready}, 2'b00);
        end else if (bus.req0_valid || bus.req1_valid) begin
          if (bus.req0_valid && bus.req1_valid) arb_g = ~model_last;
          else                                  arb_g = bus.req1_valid;
          check("grant", {bus.req1_ready, bus.req0_ready}, arb_g ? 2'b10 : 2'b01);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int           acc, at;
    logic [W-1:0] bp_a, bp_b;

    set_req(1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_resp_valid", {bus.resp1_valid, bus.resp0_valid}, 2'b00);
    check("rst_resp_p", bus.resp_p, '0);
    check("rst_resp_err", bus.resp_err, 1'b0);
    check("rst_mul_valid", bus.mul_valid, 1'b0);
    check("rst_mul_ab", {bus.mul_a, bus.mul_b}, '0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Single request 3 * -5, multiplier answers 4 cycles after its start
    issue(1'b0, 8'd3, 8'hFB, 4, acc);
    @(negedge clk);
    check("mul_valid_lat", bus.mul_valid, 1'b1);
    wait_resp(1'b0, 40, at);
    if (at >= 0) begin
      check("single_latency", at - acc, 6);
      check("single_p", bus.resp_p, 16'hFFF1);
      check("single_err", bus.resp_err, 1'b0);
      check("single_other_valid", bus.resp1_valid, 1'b0);
    end
    wait_idle(50);

    // Contention from reset: strict alternation starting with requester 0
    reset_dut();
    drive_both(4);
    for (int i = 0; i < grant_log.size(); i++) check("alternate_grant", grant_log[i], i % 2);
    wait_idle(100);

    // Timeout: no completion, abort TIMEOUT cycles after entering WAIT
    issue(1'b1, 8'd7, 8'd9, 0, acc);
    wait_resp(1'b1, 40, at);
    if (at >= 0) begin
      check("timeout_latency", at - acc, TIMEOUT + 2);
      check("timeout_err", bus.resp_err, 1'b1);
      check("timeout_p", bus.resp_p, '0);
      @(negedge clk);
      check("timeout_back_idle", bus.busy, 1'b0);
    end
    wait_idle(50);

    // Backpressure on requester 1 while requester 0 waits
    rr_auto = 1'b0;
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b0;
    issue(1'b1, 8'hF0, 8'h11, 3, acc);
    wait_resp(1'b1, 40, at);
    bp_a = 8'h25; bp_b = 8'h9C;
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, bp_a, bp_b);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_resp1_valid", bus.resp1_valid, 1'b1);
      check("bp_req0_ready", bus.req0_ready, 1'b0);
    end
    @(posedge clk); #1;
    bus.resp1_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_req0_ready", bus.req0_ready, 1'b0);
    @(posedge clk); #1;
    bus.resp1_ready = 1'b0;
    @(negedge clk);
    check("bp_after_req0_ready", bus.req0_ready, 1'b1);
    check("bp_after_resp1_valid", bus.resp1_valid, 1'b0);
    note_accept(1'b0, bp_a, bp_b, 2);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, bp_a, bp_b);
    wait_idle(50);
    rr_auto = 1'b1;

    // Reset in the middle of WAIT, then a late completion pulse
    issue(1'b1, 8'd5, 8'd6, 0, acc);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    delay_q.delete();
    model_last = 1'b1;
    @(negedge clk);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_resp_valid", {bus.resp1_valid, bus.resp0_valid}, 2'b00);
    check("midrst_mul_valid", bus.mul_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    bus.mul_done = 1'b1;
    bus.mul_p    = 16'h1234;
    @(posedge clk); #1;
    bus.mul_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_done_valid", {bus.resp1_valid, bus.resp0_valid}, 2'b00);
      check("late_done_busy", bus.busy, 1'b0);
    end
    drive_both(1);
    if (grant_log.size() > 0) check("post_reset_grant", grant_log[0], 0);
    wait_idle(50);

    // Completion in the very cycle the timeout would fire, then one cycle late
    issue(1'b0, 8'h80, 8'h80, TIMEOUT, acc);
    wait_resp(1'b0, 40, at);
    if (at >= 0) begin
      check("coincident_err", bus.resp_err, 1'b0);
      check("coincident_p", bus.resp_p, 16'h4000);
    end
    wait_idle(50);
    issue(1'b1, 8'h03, 8'h04, TIMEOUT + 1, acc);
    wait_idle(50);

    // Stray completion pulse while idle
    @(posedge clk); #1;
    bus.mul_done = 1'b1;
    bus.mul_p    = 16'hBEEF;
    @(posedge clk); #1;
    bus.mul_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_busy", bus.busy, 1'b0);
      check("stray_valid", {bus.resp1_valid, bus.resp0_valid}, 2'b00);
      check("stray_mul_valid", bus.mul_valid, 1'b0);
    end

    // Randomized traffic from both requesters with random backpressure
    rr_random = 1'b1;
    fork
      req_proc(1'b0, 25);
      req_proc(1'b1, 25);
    join
    wait_idle(400);
    rr_random = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_arbiter.md
BOOTH_ARBITER -- requirements
Module: booth_arbiter

Interface
REQ-001 Parameter W, default 8, operand width of each multiplicand and multiplier in bits.
REQ-002 Parameter TIMEOUT, default 64, maximum WAIT cycles before an operation is aborted (legal range 2..255).
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 req0_valid / req1_valid  input  1  requester 0/1 has an operand pair pending.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  W each  signed operands of requester 0/1.
REQ-007 req0_ready / req1_ready  output  1  arbiter accepts the operands this cycle.
REQ-008 resp0_valid / resp1_valid  output  1  result for requester 0/1 is available.
REQ-009 resp0_ready / resp1_ready  input  1  requester 0/1 consumes its result.
REQ-010 resp_p  output  2W  signed product, shared by both response ports.
REQ-011 resp_err  output  1  qualifies resp_p; high means a timeout occurred and resp_p is 0.
REQ-012 mul_valid  output  1  single-cycle start pulse to the Booth multiplier.
REQ-013 mul_a, mul_b  output  W each  operands driven to the multiplier.
REQ-014 mul_done  input  1  multiplier completion pulse.
REQ-015 mul_p  input  2W  multiplier product, valid in the cycle mul_done is high.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP.
REQ-018 In IDLE, reqX_ready SHALL equal (state==IDLE && grant==X); this is combinational; the non-granted ready SHALL be 0.
REQ-019 Grant rule: if only one req_valid is high, that requester is granted; if both are high, the requester other than last_grant is granted.
REQ-020 An accept happens when reqX_valid && reqX_ready: latch a, b and the owner id, then go to ISSUE.
REQ-021 ISSUE lasts exactly 1 cycle: mul_valid=1, mul_a/mul_b carry the latched operands, WAIT timer cleared to 0, next state WAIT.
REQ-022 mul_a/mul_b SHALL hold the latched operands from ISSUE through RESP; mul_valid SHALL be 0 outside ISSUE.
REQ-023 WAIT, mul_done=1: capture mul_p into resp_p, resp_err=0, go to RESP.
REQ-024 WAIT, mul_done=0: increment the timer; when the timer equals TIMEOUT-1, set resp_p=0 and resp_err=1 and go to RESP.
REQ-025 If mul_done and the timeout condition occur in the same cycle, mul_done wins and the result is captured normally.
REQ-026 mul_done SHALL be ignored in IDLE, ISSUE and RESP.
REQ-027 In RESP, only the owner's respX_valid is high; resp_p and resp_err SHALL be held stable until respX_ready=1.
REQ-028 On respX_ready in RESP: last_grant becomes the owner, next state IDLE, and respX_valid drops the next cycle.
REQ-029 The other requester's resp_ready SHALL be ignored.
REQ-030 A new request SHALL NOT be accepted before the cycle after the response handshake, because ready is only asserted in IDLE.
REQ-031 Minimum latency: accept at T, mul_valid at T+1, mul_done sampled at T+2 or later, respX_valid the cycle after mul_done.

Reset
REQ-032 Asserting rst (low) SHALL immediately force: state IDLE, last_grant=1 (requester 0 has priority first), timer 0, mul_valid 0, mul_a/mul_b 0, resp_p 0, resp_err 0, resp0/1_valid 0, busy 0.
REQ-033 A reset during ISSUE, WAIT or RESP SHALL abandon the in-flight operation with no response; a late mul_done after release SHALL be ignored.

Verification
REQ-034 Single request: req0 a=3, b=-5 accepted; multiplier returns done 4 cycles after mul_valid with mul_p=-15 -> resp0_valid with resp_p=-15 (0x...FFF1), resp_err=0; resp1_valid stays 0.
REQ-035 Contention: both valid from reset -> req0 served first, then req1; with both held high, grants alternate 0,1,0,1 over 4 operations.
REQ-036 Timeout: TIMEOUT=8, mul_done never asserted -> resp_err=1 and resp_p=0 exactly 8 cycles after entering WAIT; FSM returns to IDLE after resp_ready.
REQ-037 Backpressure: resp1_ready held low 10 cycles -> resp1_valid, resp_p and resp_err stable; req0_ready=0 throughout; req0 accepted the cycle after the handshake.
REQ-038 Reset mid-WAIT: rst low for 1 cycle during WAIT, then mul_done pulses -> no resp_valid, busy=0, next grant goes to requester 0.
REQ-039 Boundary: mul_done coincident with the timeout cycle -> resp_err=0 and resp_p=mul_p; a stray mul_done in IDLE -> no state change.
